// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        FLUSH
    } t_fetch_state;

    localparam int unsigned FIFO_DEPTH  = 2;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small shifting register FIFO holding fetched {instr, pc} pairs; entry 0 is the head.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned INSTR_WIDTH = 32,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_arstn,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    output logic [CW-1:0]          o_count,
    output logic [INSTR_WIDTH-1:0] o_head_instr,
    output logic [ADDR_WIDTH-1:0]  o_head_pc
);

    logic [INSTR_WIDTH-1:0] instr_q [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_q    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_d    [FIFO_DEPTH];
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [CW-1:0]          wr_idx;
    logic                   pop_ok;
    logic                   push_ok;

    assign pop_ok  = i_pop && (count_q != '0);
    assign push_ok = i_push && ((count_q < CW'(FIFO_DEPTH)) || pop_ok);

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        count_d = count_q;
        wr_idx  = count_q;
        if (i_clear) begin
            count_d = '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                    instr_d[i] = instr_q[i+1];
                    pc_d[i]    = pc_q[i+1];
                end
                wr_idx  = count_q - CW'(1);
                count_d = count_q - CW'(1);
            end
            // The push lands in the slot just past the (post-pop) last entry.
            if (push_ok) begin
                for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                    if (CW'(i) == wr_idx) begin
                        instr_d[i] = i_instr;
                        pc_d[i]    = i_pc;
                    end
                end
                count_d = count_d + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            count_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            count_q <= count_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign o_count      = count_q;
    assign o_head_instr = instr_q[0];
    assign o_head_pc    = pc_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM and a 2-entry fetch buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = 64,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   i_clk,
    input  logic                   i_arstn,
    output logic                   o_imem_req_valid,
    input  logic                   i_imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_imem_req_addr,
    input  logic                   i_imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_instr_valid,
    input  logic                   i_decode_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc_plus4
);

    localparam int unsigned          CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] PC_INC    = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

    t_fetch_state           state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  req_pc_q;

    logic [CW-1:0]          fifo_count;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic                   slot_free;
    logic                   req_valid;
    logic                   handshake;
    logic                   rsp_owed;
    logic                   push;
    logic                   pop;

    // The slot check deliberately ignores a same-cycle pop so the FIFO can never overflow.
    assign slot_free = fifo_count < CW'(FIFO_DEPTH);
    // Gated by reset so the request is quiet while reset is held.
    assign req_valid = i_arstn && (state_q == REQ) && slot_free;
    assign handshake = req_valid && i_imem_req_ready;
    assign rsp_owed  = (state_q == WAIT) || (state_q == FLUSH);

    assign push = !i_redirect && (state_q == WAIT) && i_imem_rsp_valid;
    assign pop  = !i_redirect && o_instr_valid && i_decode_ready;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC & ALIGN_MSK;
            req_pc_q <= '0;
        end else if (i_redirect) begin
            pc_q <= i_redirect_pc & ALIGN_MSK;
            if (rsp_owed && i_imem_rsp_valid) begin
                state_q <= REQ;
            end else if (rsp_owed || handshake) begin
                state_q <= FLUSH;
            end else begin
                state_q <= REQ;
            end
        end else begin
            unique case (state_q)
                REQ: begin
                    if (handshake) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + PC_INC;
                        state_q  <= WAIT;
                    end
                end
                WAIT, FLUSH: begin
                    if (i_imem_rsp_valid) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase
        end
    end

    fetch_fifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_fetch_fifo (
        .i_clk        (i_clk),
        .i_arstn      (i_arstn),
        .i_push       (push),
        .i_pop        (pop),
        .i_clear      (i_redirect),
        .i_instr      (i_imem_rsp_data),
        .i_pc         (req_pc_q),
        .o_count      (fifo_count),
        .o_head_instr (head_instr),
        .o_head_pc    (head_pc)
    );

    assign o_imem_req_valid = req_valid;
    assign o_imem_req_addr  = req_valid ? pc_q : '0;
    assign o_instr_valid    = fifo_count != '0;
    assign o_instr          = o_instr_valid ? head_instr : '0;
    assign o_instr_pc       = o_instr_valid ? head_pc : '0;
    assign o_instr_pc_plus4 = o_instr_valid ? head_pc + PC_INC : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random memory/decode/redirect traffic against a program-order model.
module tb_fetch_unit;

    localparam int unsigned     AW     = 64;
    localparam int unsigned     IW     = 32;
    localparam logic [AW-1:0]   RST_PC = '0;

    logic          i_clk = 1'b0;
    logic          i_arstn = 1'b0;
    logic          o_imem_req_valid;
    logic          i_imem_req_ready = 1'b0;
    logic [AW-1:0] o_imem_req_addr;
    logic          i_imem_rsp_valid = 1'b0;
    logic [IW-1:0] i_imem_rsp_data = '0;
    logic          i_redirect = 1'b0;
    logic [AW-1:0] i_redirect_pc = '0;
    logic          o_instr_valid;
    logic          i_decode_ready = 1'b0;
    logic [IW-1:0] o_instr;
    logic [AW-1:0] o_instr_pc;
    logic [AW-1:0] o_instr_pc_plus4;

    always #5 i_clk = ~i_clk;

    fetch_unit #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (RST_PC)
    ) dut (
        .i_clk            (i_clk),
        .i_arstn          (i_arstn),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .i_decode_ready   (i_decode_ready),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .o_instr_pc_plus4 (o_instr_pc_plus4)
    );

    int total = 0;
    int bad = 0;

    // Memory model: one pending request, answered after mem_cnt further cycles.
    bit            mem_busy = 1'b0;
    bit            mem_stale = 1'b0;
    int            mem_cnt = 0;
    logic [AW-1:0] mem_addr = '0;
    // Program-order model: next request address, next decoded PC, instructions buffered.
    logic [AW-1:0] exp_req = RST_PC;
    logic [AW-1:0] exp_pc = RST_PC;
    int            buffered = 0;
    bit            prev_hold = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    int            rdy_pct = 100;
    int            dec_pct = 100;
    int            redir_pct = 0;
    int            lat_min = 0;
    int            lat_max = 0;
    bit            force_redir = 1'b0;
    bit            inject_rsp = 1'b0;
    logic [AW-1:0] redir_target = '0;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
        check("rst_req_addr", o_imem_req_addr, 64'd0);
        check("rst_instr_valid", 64'(o_instr_valid), 64'd0);
        check("rst_instr", 64'(o_instr), 64'd0);
        check("rst_instr_pc", o_instr_pc, 64'd0);
        check("rst_pc_plus4", o_instr_pc_plus4, 64'd0);
    endtask

    task automatic step();
        bit            rsp;
        bit            hs;
        bit            pop;
        bit            redir;
        logic [AW-1:0] tgt;
        @(negedge i_clk);
        rsp              = mem_busy && (mem_cnt == 0);
        i_imem_rsp_valid = rsp || (inject_rsp && !mem_busy);
        i_imem_rsp_data  = rsp ? mem_word(mem_addr) : IW'($urandom);
        i_imem_req_ready = pct(rdy_pct);
        i_decode_ready   = pct(dec_pct);
        redir            = force_redir || pct(redir_pct);
        tgt              = force_redir ? redir_target : {$urandom, $urandom};
        i_redirect       = redir;
        i_redirect_pc    = tgt;
        #1;
        // A request is due exactly when nothing is owed and the buffer has room.
        check("req_valid", 64'(o_imem_req_valid), 64'(!mem_busy && buffered < 2));
        check("instr_valid", 64'(o_instr_valid), 64'(buffered != 0));
        if (prev_hold) check("req_addr_stable", o_imem_req_addr, prev_addr);
        hs = o_imem_req_valid && i_imem_req_ready;
        if (hs) check("req_addr", o_imem_req_addr, exp_req);
        pop = o_instr_valid && i_decode_ready && !redir;
        if (pop) begin
            check("instr_pc", o_instr_pc, exp_pc);
            check("instr_data", 64'(o_instr), 64'(mem_word(exp_pc)));
            check("pc_plus4", o_instr_pc_plus4, exp_pc + 64'd4);
            exp_pc = exp_pc + 64'd4;
        end
        if (rsp) begin
            mem_busy = 1'b0;
            if (!mem_stale && !redir) buffered++;
            mem_stale = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (pop) buffered--;
        if (hs) begin
            mem_busy  = 1'b1;
            mem_stale = 1'b0;
            mem_addr  = o_imem_req_addr;
            mem_cnt   = int'($urandom_range(lat_max, lat_min));
            exp_req   = exp_req + 64'd4;
        end
        if (redir) begin
            buffered = 0;
            if (mem_busy) mem_stale = 1'b1;
            exp_req = tgt & ~64'h3;
            exp_pc  = tgt & ~64'h3;
        end
        prev_hold = o_imem_req_valid && !i_imem_req_ready && !redir;
        prev_addr = o_imem_req_addr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_outputs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_arstn = 1'b1;

        // Always-ready 1-cycle memory, decode always ready.
        repeat (20) step();

        // Decode stalls: the buffer fills and requests stop, then drain.
        dec_pct = 0;
        repeat (12) step();
        dec_pct = 100;
        repeat (6) step();

        // Redirect to 0x1003 while a request is outstanding with a slow response.
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 10 && !mem_busy; i++) step();
        check("reach_wait_a", 64'(mem_busy), 64'd1);
        force_redir  = 1'b1;
        redir_target = 64'h1003;
        step();
        force_redir = 1'b0;
        repeat (10) step();

        // Redirect in the same cycle as a request handshake.
        lat_min = 0;
        lat_max = 0;
        for (int i = 0; i < 10 && (mem_busy || buffered >= 2); i++) step();
        force_redir  = 1'b1;
        redir_target = 64'h0000_0000_0000_2468;
        step();
        force_redir = 1'b0;
        repeat (8) step();

        // Memory not ready for a while: request held with a stable address.
        rdy_pct = 0;
        repeat (6) step();
        rdy_pct = 100;
        repeat (4) step();

        // Random traffic: partial ready, partial decode, variable latency, redirects.
        rdy_pct   = 70;
        dec_pct   = 60;
        lat_max   = 3;
        redir_pct = 5;
        repeat (400) step();

        // Reset while a response is owed; the late stray response must be ignored.
        redir_pct = 0;
        rdy_pct   = 100;
        lat_min   = 2;
        lat_max   = 2;
        for (int i = 0; i < 10 && !mem_busy; i++) step();
        check("reach_wait_b", 64'(mem_busy), 64'd1);
        @(negedge i_clk);
        i_arstn = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge i_clk);
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_redirect       = 1'b0;
        i_arstn          = 1'b1;
        mem_busy  = 1'b0;
        mem_stale = 1'b0;
        buffered  = 0;
        exp_req   = RST_PC;
        exp_pc    = RST_PC;
        prev_hold = 1'b0;
        lat_min   = 0;
        lat_max   = 0;
        rdy_pct    = 0;
        inject_rsp = 1'b1;
        repeat (3) step();
        inject_rsp = 1'b0;
        rdy_pct    = 100;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
